mouse_cfg_sequencer: RTL and testbench

Programs a streaming PS/2 mouse with sample rate, resolution and 1:1 scaling. It owns the PS/2 transmitter/receiver handshake for the duration of one configuration run, started by a START pulse from the mouse master state machine. It sends the fixed 5-byte sequence F3, rate, E8, resolution, E6, and checks for an FA acknowledge after every byte. It handles resend (FE) retries, response timeouts and bad responses, and reports DONE or ERROR with a code.

---
 rtl/ps2_pkg.sv | 45 ++++
 rtl/ps2_timeout_timer.sv | 28 ++
 rtl/mouse_cfg_sequencer.sv | 162 ++++++++++++++++
 tb/tb_mouse_cfg_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 mouse constants: command and response bytes, error codes,
// configuration FSM state encoding and the configuration byte sequence.
package ps2_pkg;

   localparam logic [7:0] CMD_RESET     = 8'hFF;
   localparam logic [7:0] CMD_STREAM_EN = 8'hF4;
   localparam logic [7:0] CMD_SET_RATE  = 8'hF3;
   localparam logic [7:0] CMD_SET_RES   = 8'hE8;
   localparam logic [7:0] CMD_SCALE11   = 8'hE6;

   localparam logic [7:0] RSP_ACK       = 8'hFA;
   localparam logic [7:0] RSP_RESEND    = 8'hFE;
   localparam logic [7:0] RSP_FAIL      = 8'hFC;
   localparam logic [7:0] RSP_SELFTEST  = 8'hAA;

   localparam logic [1:0] ERR_NONE      = 2'b00;
   localparam logic [1:0] ERR_RETRY     = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT   = 2'b10;
   localparam logic [1:0] ERR_BAD_RESP  = 2'b11;

   localparam logic [2:0] LAST_INDEX    = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND,
      ST_WAIT_SENT,
      ST_WAIT_ACK,
      ST_FINISH,
      ST_FAIL
   } cfg_state_t;

   // Byte sequence: F3, rate, E8, resolution, E6.
   function automatic logic [7:0] cfg_byte(input logic [2:0] index,
                                           input logic [7:0] rate,
                                           input logic [1:0] res);
      case (index)
         3'd0:    cfg_byte = CMD_SET_RATE;
         3'd1:    cfg_byte = rate;
         3'd2:    cfg_byte = CMD_SET_RES;
         3'd3:    cfg_byte = {6'b0, res};
         default: cfg_byte = CMD_SCALE11;
      endcase
   endfunction

endpackage

// File: rtl/ps2_timeout_timer.sv
// Cycle counter with a sticky EXPIRED flag that rises after TIMEOUT_CYCLES
// enabled cycles since the last CLEAR.
module ps2_timeout_timer #(
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic CLK,
   input  logic RESET,
   input  logic CLEAR,
   input  logic ENABLE,
   output logic EXPIRED
);

   localparam int W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

   logic [W-1:0] count;

   always_ff @(posedge CLK) begin
      if (RESET || CLEAR) begin
         count   <= '0;
         EXPIRED <= 1'b0;
      end else if (ENABLE && !EXPIRED) begin
         count <= count + W'(1);
         if (count == LAST) EXPIRED <= 1'b1;
      end
   end

endmodule

// File: rtl/mouse_cfg_sequencer.sv
// Sends F3 rate E8 res E6 to a streaming PS/2 mouse, checking for FA after
// each byte with resend retries, per-byte timeout and bad-response abort.
module mouse_cfg_sequencer #(
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int MAX_RETRY      = 3
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       START,
   input  logic [7:0] CFG_RATE,
   input  logic [1:0] CFG_RES,
   output logic       BUSY,
   output logic       DONE,
   output logic       ERROR,
   output logic [1:0] ERR_CODE,
   output logic       SEND_BYTE,
   output logic [7:0] BYTE_TO_SEND,
   input  logic       BYTE_SENT,
   output logic       READ_ENABLE,
   input  logic [7:0] BYTE_READ,
   input  logic [1:0] BYTE_ERROR_CODE,
   input  logic       BYTE_READY
);
   import ps2_pkg::*;

   localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);

   cfg_state_t state, state_next;
   logic [2:0] index, index_next;
   logic [3:0] retry, retry_next;
   logic [7:0] rate, rate_next;
   logic [1:0] res, res_next;
   logic [1:0] code, code_next;
   logic       expired;

   logic       busy_next, done_next, error_next, send_next, read_en_next;
   logic [1:0] err_code_next;
   logic [7:0] byte_next;

   // Two register stages (FSM state, ERROR) follow the timer flag, so the
   // timer is shortened by two to land ERROR exactly TIMEOUT_CYCLES after SEND_BYTE.
   ps2_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES - 2)) u_timer (
      .CLK     (CLK),
      .RESET   (RESET),
      .CLEAR   (state == ST_SEND),
      .ENABLE  ((state == ST_WAIT_SENT) || (state == ST_WAIT_ACK)),
      .EXPIRED (expired)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state <= ST_IDLE;
         index <= '0;
         retry <= '0;
         rate  <= '0;
         res   <= '0;
         code  <= ERR_NONE;
      end else begin
         state <= state_next;
         index <= index_next;
         retry <= retry_next;
         rate  <= rate_next;
         res   <= res_next;
         code  <= code_next;
      end
   end

   // SEND_BYTE/BYTE_SENT and BYTE_READY are one-cycle pulses with no
   // back-pressure; a response or completion pulse beats a same-cycle timeout.
   always_comb begin
      state_next = state;
      index_next = index;
      retry_next = retry;
      rate_next  = rate;
      res_next   = res;
      code_next  = code;
      case (state)
         ST_IDLE: if (START) begin
            state_next = ST_SEND;
            index_next = '0;
            retry_next = '0;
            rate_next  = CFG_RATE;
            res_next   = CFG_RES;
            code_next  = ERR_NONE;
         end
         ST_SEND: state_next = ST_WAIT_SENT;
         ST_WAIT_SENT: begin
            if (BYTE_SENT) state_next = ST_WAIT_ACK;
            else if (expired) begin
               state_next = ST_FAIL;
               code_next  = ERR_TIMEOUT;
            end
         end
         ST_WAIT_ACK: begin
            if (BYTE_READY) begin
               if (BYTE_ERROR_CODE != 2'b00) begin
                  state_next = ST_FAIL;
                  code_next  = ERR_BAD_RESP;
               end else if (BYTE_READ == RSP_ACK) begin
                  if (index == LAST_INDEX) state_next = ST_FINISH;
                  else begin
                     state_next = ST_SEND;
                     index_next = index + 3'd1;
                     retry_next = '0;
                  end
               end else if (BYTE_READ == RSP_RESEND) begin
                  if (retry < RETRY_LIMIT) begin
                     state_next = ST_SEND;
                     retry_next = retry + 4'd1;
                  end else begin
                     state_next = ST_FAIL;
                     code_next  = ERR_RETRY;
                  end
               end else begin
                  state_next = ST_FAIL;
                  code_next  = ERR_BAD_RESP;
               end
            end else if (expired) begin
               state_next = ST_FAIL;
               code_next  = ERR_TIMEOUT;
            end
         end
         ST_FINISH: state_next = ST_IDLE;
         ST_FAIL:   state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      busy_next     = (state != ST_IDLE);
      done_next     = (state == ST_FINISH);
      error_next    = (state == ST_FAIL);
      send_next     = (state == ST_SEND);
      read_en_next  = (state == ST_WAIT_ACK);
      byte_next     = BYTE_TO_SEND;
      err_code_next = ERR_CODE;
      if (state == ST_SEND) byte_next = cfg_byte(index, rate, res);
      if (state == ST_IDLE && START) err_code_next = ERR_NONE;
      else if (state == ST_FAIL) err_code_next = code;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         BUSY         <= 1'b0;
         DONE         <= 1'b0;
         ERROR        <= 1'b0;
         ERR_CODE     <= ERR_NONE;
         SEND_BYTE    <= 1'b0;
         BYTE_TO_SEND <= 8'h00;
         READ_ENABLE  <= 1'b0;
      end else begin
         BUSY         <= busy_next;
         DONE         <= done_next;
         ERROR        <= error_next;
         ERR_CODE     <= err_code_next;
         SEND_BYTE    <= send_next;
         BYTE_TO_SEND <= byte_next;
         READ_ENABLE  <= read_en_next;
      end
   end

endmodule

// File: tb/tb_mouse_cfg_sequencer.sv
// Directed bench: a scripted mouse responder, a transcript model computing the
// expected byte stream and outcome, and a per-cycle compare process.
module tb_mouse_cfg_sequencer;

   localparam int T    = 100;
   localparam int MAXR = 3;

   logic       CLK = 1'b0;
   logic       RESET, START, BYTE_SENT, BYTE_READY;
   logic [7:0] CFG_RATE, BYTE_READ;
   logic [1:0] CFG_RES, BYTE_ERROR_CODE;
   logic       BUSY, DONE, ERROR, SEND_BYTE, READ_ENABLE;
   logic [1:0] ERR_CODE;
   logic [7:0] BYTE_TO_SEND;

   mouse_cfg_sequencer #(.TIMEOUT_CYCLES(T), .MAX_RETRY(MAXR)) dut (
      .CLK(CLK), .RESET(RESET), .START(START), .CFG_RATE(CFG_RATE), .CFG_RES(CFG_RES),
      .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR), .ERR_CODE(ERR_CODE),
      .SEND_BYTE(SEND_BYTE), .BYTE_TO_SEND(BYTE_TO_SEND), .BYTE_SENT(BYTE_SENT),
      .READ_ENABLE(READ_ENABLE), .BYTE_READ(BYTE_READ),
      .BYTE_ERROR_CODE(BYTE_ERROR_CODE), .BYTE_READY(BYTE_READY)
   );

   always #5 CLK = ~CLK;

   // mode: 0 normal, 1 BYTE_SENT never comes, 2 ack in the expiry cycle, 3 ack one cycle late
   typedef struct {
      logic [7:0] data;
      logic [1:0] err;
      int         mode;
   } resp_t;

   resp_t      script[$];
   logic [7:0] exp_q[$];
   logic       exp_done;
   logic [1:0] exp_code;
   bit         exp_timeout;
   bit         expect_end = 0;
   int         end_count = 0;
   int         cyc = 0;
   int         last_send_cyc = 0;
   int         vectors = 0;
   int         miscompares = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic add(input logic [7:0] d, input logic [1:0] e, input int m);
      resp_t r;
      r.data = d; r.err = e; r.mode = m;
      script.push_back(r);
   endtask

   // Transcript model: walk the 5-byte sequence against the scripted responses.
   task automatic model_run(input logic [7:0] rate, input logic [1:0] res);
      logic [7:0] seq [5];
      int idx = 0, retries = 0, k = 0;
      resp_t r;
      seq = '{8'hF3, rate, 8'hE8, {6'b0, res}, 8'hE6};
      exp_q.delete();
      exp_timeout = 0;
      exp_done = 0;
      while (1) begin
         exp_q.push_back(seq[idx]);
         r = script[k]; k++;
         if (r.mode == 1 || r.mode == 3) begin exp_code = 2'b10; exp_timeout = 1; return; end
         if (r.err != 2'b00) begin exp_code = 2'b11; return; end
         if (r.data == 8'hFA) begin
            idx++; retries = 0;
            if (idx == 5) begin exp_done = 1; exp_code = 2'b00; return; end
         end else if (r.data == 8'hFE) begin
            if (retries < MAXR) retries++;
            else begin exp_code = 2'b01; return; end
         end else begin
            exp_code = 2'b11; return;
         end
      end
   endtask

   always @(negedge CLK) begin
      cyc++;
      if (RESET !== 1'b1) begin
         if (SEND_BYTE === 1'b1) begin
            last_send_cyc = cyc;
            check("send_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("byte_to_send", BYTE_TO_SEND, exp_q.pop_front());
         end
         if (DONE === 1'b1 || ERROR === 1'b1) begin
            check("end_expected", expect_end, 1);
            if (expect_end) begin
               check("outcome", {BUSY, DONE, ERROR, ERR_CODE}, {1'b1, exp_done, !exp_done, exp_code});
               check("sends_left", exp_q.size(), 0);
               if (exp_timeout) check("timeout_delay", cyc - last_send_cyc, T);
               expect_end = 0;
               end_count++;
            end
         end
      end
   end

   task automatic serve(input resp_t r, input bit poke);
      int ready_at;
      ready_at = (r.mode == 2) ? T - 2 : (r.mode == 3) ? T - 1 : 5;
      for (int rc = 0; rc <= ready_at; rc++) begin
         BYTE_SENT       = (rc == 2) && (r.mode != 1);
         BYTE_READY      = 1'b0;
         BYTE_READ       = 8'h00;
         BYTE_ERROR_CODE = 2'b00;
         START           = poke && (rc == 1);
         if (poke && rc == 1) begin CFG_RATE = 8'h33; CFG_RES = 2'd0; end
         if (r.mode == 0 && rc == 1) begin
            BYTE_READY = 1'b1; BYTE_READ = 8'hFC; BYTE_ERROR_CODE = 2'b11;
         end
         if (r.mode != 1 && rc == ready_at) begin
            BYTE_READY = 1'b1; BYTE_READ = r.data; BYTE_ERROR_CODE = r.err;
         end
         if (r.mode == 0 && rc == ready_at) check("read_enable_ack", READ_ENABLE, 1);
         @(negedge CLK);
      end
      BYTE_SENT = 1'b0; BYTE_READY = 1'b0; START = 1'b0;
   endtask

   task automatic run(input logic [7:0] rate, input logic [1:0] res, input bit poke);
      int ends0, k = 0, budget = 0;
      resp_t r;
      model_run(rate, res);
      ends0 = end_count;
      expect_end = 1;
      START = 1'b1; CFG_RATE = rate; CFG_RES = res;
      @(negedge CLK);
      START = 1'b0; CFG_RATE = ~rate; CFG_RES = ~res;
      @(negedge CLK);
      check("start_latency", {BUSY, SEND_BYTE, ERR_CODE}, 4'b1100);
      while (end_count == ends0 && budget < 4000) begin
         if (SEND_BYTE) begin
            r = script[k]; k++;
            check("read_enable_idle", READ_ENABLE, 0);
            serve(r, poke && k == 1);
         end else begin
            @(negedge CLK);
            budget++;
         end
      end
      check("run_end_seen", end_count - ends0, 1);
      @(negedge CLK);
      check("idle_after_end", {BUSY, READ_ENABLE, SEND_BYTE}, 0);
      check("err_code_held", ERR_CODE, exp_code);
   endtask

   task automatic reset_mid_run();
      int waited = 0;
      logic acc;
      script.delete();
      repeat (5) add(8'hFA, 2'b00, 0);
      model_run(8'h28, 2'd1);
      expect_end = 1;
      START = 1'b1; CFG_RATE = 8'h28; CFG_RES = 2'd1;
      @(negedge CLK);
      START = 1'b0;
      repeat (3) @(negedge CLK);
      BYTE_SENT = 1'b1;
      @(negedge CLK);
      BYTE_SENT = 1'b0;
      while (!READ_ENABLE && waited < 10) begin @(negedge CLK); waited++; end
      check("read_enable_before_reset", READ_ENABLE, 1);
      RESET = 1'b1;
      @(negedge CLK);
      check("outputs_in_reset",
            {BUSY, DONE, ERROR, ERR_CODE, SEND_BYTE, BYTE_TO_SEND, READ_ENABLE}, 0);
      RESET = 1'b0;
      exp_q.delete();
      expect_end = 0;
      acc = 1'b0;
      repeat (20) begin
         @(negedge CLK);
         acc = acc | SEND_BYTE | DONE | ERROR | BUSY | READ_ENABLE;
      end
      check("quiet_after_reset", acc, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      RESET = 1'b1; START = 1'b0; CFG_RATE = 8'h00; CFG_RES = 2'd0;
      BYTE_SENT = 1'b0; BYTE_READY = 1'b0; BYTE_READ = 8'h00; BYTE_ERROR_CODE = 2'b00;
      repeat (3) @(negedge CLK);
      check("reset_values", {BUSY, DONE, ERROR, ERR_CODE, SEND_BYTE, BYTE_TO_SEND, READ_ENABLE}, 0);
      RESET = 1'b0;
      @(negedge CLK);

      // Clean run
      script.delete();
      repeat (5) add(8'hFA, 2'b00, 0);
      model_run(8'h64, 2'd2);
      check("model_clean_seq", {exp_q[0], exp_q[1], exp_q[2], exp_q[3], exp_q[4]}, 40'hF364E802E6);
      check("model_clean_done", {exp_done, exp_code}, 3'b100);
      run(8'h64, 2'd2, 0);

      // Two resends of the rate byte, START poked while busy
      script.delete();
      add(8'hFA, 2'b00, 0); add(8'hFE, 2'b00, 0); add(8'hFE, 2'b00, 0);
      repeat (4) add(8'hFA, 2'b00, 0);
      model_run(8'h64, 2'd1);
      check("model_resend_len", exp_q.size(), 7);
      check("model_resend_rate", {exp_q[1], exp_q[2], exp_q[3]}, 24'h646464);
      run(8'h64, 2'd1, 1);

      // Retry exhaustion on E8
      script.delete();
      add(8'hFA, 2'b00, 0); add(8'hFA, 2'b00, 0);
      repeat (4) add(8'hFE, 2'b00, 0);
      model_run(8'h0A, 2'd0);
      check("model_retry_len", exp_q.size(), 6);
      check("model_retry_code", {exp_done, exp_code, exp_q[5]}, {1'b0, 2'b01, 8'hE8});
      run(8'h0A, 2'd0, 0);

      // FC after the rate byte
      script.delete();
      add(8'hFA, 2'b00, 0); add(8'hFC, 2'b00, 0);
      run(8'h07, 2'd3, 0);

      // FA with receiver error on F3
      script.delete();
      add(8'hFA, 2'b01, 0);
      run(8'hC8, 2'd2, 0);

      // BYTE_SENT never arrives for E8
      script.delete();
      add(8'hFA, 2'b00, 0); add(8'hFA, 2'b00, 0); add(8'h00, 2'b00, 1);
      model_run(8'h50, 2'd1);
      check("model_timeout_code", {exp_done, exp_code, exp_timeout}, 4'b0101);
      run(8'h50, 2'd1, 0);

      // Ack in the expiry cycle wins over the timeout
      script.delete();
      add(8'hFA, 2'b00, 0); add(8'hFA, 2'b00, 2);
      repeat (3) add(8'hFA, 2'b00, 0);
      run(8'h14, 2'd3, 0);

      // Ack one cycle after expiry is too late
      script.delete();
      add(8'hFA, 2'b00, 3);
      run(8'h3C, 2'd0, 0);

      reset_mid_run();

      script.delete();
      repeat (5) add(8'hFA, 2'b00, 0);
      run(8'hC8, 2'd3, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
